// File: rtl/reset_sequencer.sv
// Board reset sequencer: synchronises reset_n, holds all domains, then releases rst[] in stages.
// Optional cause output is enabled by defining RESET_CAUSE_EN.
module reset_sequencer #(
    parameter int unsigned NUM_DOMAINS     = 2,
    parameter int unsigned HOLD_CYCLES     = 63,
    parameter int unsigned STAGE_GAP       = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   btn_n,
    input  logic                   sw_req,
    output logic [NUM_DOMAINS-1:0] rst,
    output logic                   ready
`ifdef RESET_CAUSE_EN
    ,
    output logic [1:0]             cause
`endif
);

    localparam int unsigned HOLD_W  = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned STAGE_W = $clog2(STAGE_GAP + 1);
    localparam int unsigned DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(STAGE_GAP - 1);
    localparam logic [DEB_W-1:0]   DEB_MAX    = DEB_W'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_STAGE = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    logic                   arst_s1_q, arst_sync_q;
    logic                   btn_s1_q, btn_s2_q;
    logic [DEB_W-1:0]       deb_q, deb_d;
    logic                   press_edge;
    logic                   btn_hold_q;
    logic                   trig_q, trig_d;
    state_e                 state_q;
    logic [HOLD_W-1:0]      hold_q;
    logic [STAGE_W-1:0]     stage_q;
    logic [NUM_DOMAINS-1:0] rst_q, rst_shift;
    logic                   ready_q;
    logic                   last_release;

    // Reset release synchroniser; the sequencer is frozen until arst_sync_q is high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            arst_s1_q   <= 1'b0;
            arst_sync_q <= 1'b0;
        end else begin
            arst_s1_q   <= 1'b1;
            arst_sync_q <= arst_s1_q;
        end
    end

    // Button synchroniser clears to the idle (released) level so reset never fakes a press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_s1_q   <= 1'b1;
            btn_s2_q   <= 1'b1;
            deb_q      <= '0;
            btn_hold_q <= 1'b0;
            trig_q     <= 1'b0;
        end else begin
            btn_s1_q   <= btn_n;
            btn_s2_q   <= btn_s1_q;
            deb_q      <= deb_d;
            btn_hold_q <= (deb_q == DEB_MAX);
            trig_q     <= trig_d;
        end
    end

    always_comb begin
        deb_d = deb_q;
        if (btn_s2_q) begin
            deb_d = '0;
        end else if (deb_q != DEB_MAX) begin
            deb_d = deb_q + DEB_W'(1);
        end
        press_edge = (deb_d == DEB_MAX) && (deb_q != DEB_MAX);
        trig_d     = arst_sync_q && (sw_req || press_edge);
    end

    assign rst_shift    = rst_q << 1;
    assign last_release = (rst_shift == '0);

    // Sequencer: hold, staged thermometer release, run; a registered trigger restarts the hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_HOLD;
            hold_q  <= '0;
            stage_q <= '0;
            rst_q   <= '1;
            ready_q <= 1'b0;
        end else if (arst_sync_q) begin
            if (trig_q) begin
                state_q <= ST_HOLD;
                hold_q  <= '0;
                stage_q <= '0;
                rst_q   <= '1;
                ready_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_HOLD: begin
                        if (btn_hold_q) begin
                            hold_q <= '0;
                        end else if (hold_q == HOLD_LAST) begin
                            hold_q  <= '0;
                            stage_q <= '0;
                            rst_q   <= rst_shift;
                            if (last_release) begin
                                state_q <= ST_RUN;
                                ready_q <= 1'b1;
                            end else begin
                                state_q <= ST_STAGE;
                            end
                        end else begin
                            hold_q <= hold_q + HOLD_W'(1);
                        end
                    end
                    ST_STAGE: begin
                        if (stage_q == STAGE_LAST) begin
                            stage_q <= '0;
                            rst_q   <= rst_shift;
                            if (last_release) begin
                                state_q <= ST_RUN;
                                ready_q <= 1'b1;
                            end
                        end else begin
                            stage_q <= stage_q + STAGE_W'(1);
                        end
                    end
                    ST_RUN: begin
                        ready_q <= 1'b1;
                    end
                    default: begin
                        state_q <= ST_HOLD;
                    end
                endcase
            end
        end
    end

    assign rst   = rst_q;
    assign ready = ready_q;

`ifdef RESET_CAUSE_EN
    logic       trig_sw_q;
    logic [1:0] cause_q;

    // Software wins when both sources fire in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            trig_sw_q <= 1'b0;
            cause_q   <= 2'b00;
        end else begin
            trig_sw_q <= arst_sync_q && sw_req;
            if (arst_sync_q && trig_q) begin
                cause_q <= trig_sw_q ? 2'b10 : 2'b01;
            end
        end
    end

    assign cause = cause_q;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboarded bench for reset_sequencer: three parameterisations share one stimulus stream.
module tb_reset_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       btn_n;
    logic       sw_req;
    logic [1:0] rst0;
    logic       ready0;
    logic [3:0] rst1;
    logic       ready1;
    logic [0:0] rst2;
    logic       ready2;
`ifdef RESET_CAUSE_EN
    logic [1:0] cause0, cause1, cause2;
`endif

    reset_sequencer u_dut0 (
        .clk(clk), .reset_n(reset_n), .btn_n(btn_n), .sw_req(sw_req),
        .rst(rst0), .ready(ready0)
`ifdef RESET_CAUSE_EN
        , .cause(cause0)
`endif
    );

    reset_sequencer #(.NUM_DOMAINS(4), .HOLD_CYCLES(10), .STAGE_GAP(1), .DEBOUNCE_CYCLES(4)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .btn_n(btn_n), .sw_req(sw_req),
        .rst(rst1), .ready(ready1)
`ifdef RESET_CAUSE_EN
        , .cause(cause1)
`endif
    );

    reset_sequencer #(.NUM_DOMAINS(1), .HOLD_CYCLES(3), .STAGE_GAP(2), .DEBOUNCE_CYCLES(2)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .btn_n(btn_n), .sw_req(sw_req),
        .rst(rst2), .ready(ready2)
`ifdef RESET_CAUSE_EN
        , .cause(cause2)
`endif
    );

    localparam int P_N [3] = '{2, 4, 1};
    localparam int P_H [3] = '{63, 10, 3};
    localparam int P_G [3] = '{4, 1, 2};
    localparam int P_D [3] = '{16, 4, 2};

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: cnt[k] = counting cycles since the last restart; bit i is released
    // once cnt reaches HOLD + GAP*i. Button press = DEB consecutive low samples, seen 2 edges late.
    typedef struct packed {
        logic [2:0][7:0] rst;
        logic [2:0]      rdy;
        logic [2:0][1:0] cz;
    } exp_t;

    exp_t       q[$];
    int         e;
    logic       bh1, bh2;
    int         cnt [3];
    int         lowrun [3];
    bit         p1 [3], p2 [3], tp [3], tsp [3];
    logic [1:0] cz [3];

    function automatic exp_t expected();
        exp_t r = '0;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 8; i++)
                if (i < P_N[k]) r.rst[k][i] = (cnt[k] < P_H[k] + P_G[k] * i);
            r.rdy[k] = (cnt[k] >= P_H[k] + P_G[k] * (P_N[k] - 1));
            r.cz[k]  = cz[k];
        end
        return r;
    endfunction

    task automatic model_reset();
        e = 0; bh1 = 1'b1; bh2 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cnt[k] = 0; lowrun[k] = 0; p1[k] = 0; p2[k] = 0; tp[k] = 0; tsp[k] = 0; cz[k] = 2'b00;
        end
        q.delete();
        q.push_back(expected());
    endtask

    task automatic model_step();
        logic synced;
        bit   pressed;
        e++;
        synced = bh2; bh2 = bh1; bh1 = btn_n;
        for (int k = 0; k < 3; k++) begin
            if (synced) lowrun[k] = 0;
            else if (lowrun[k] < P_D[k]) lowrun[k]++;
            pressed = (lowrun[k] == P_D[k]);
            if (e >= 3) begin
                if (tp[k]) begin
                    cnt[k] = 0;
                    cz[k]  = tsp[k] ? 2'b10 : 2'b01;
                end else if (cnt[k] < P_H[k] && p2[k]) begin
                    cnt[k] = 0;
                end else if (cnt[k] < P_H[k] + P_G[k] * P_N[k]) begin
                    cnt[k]++;
                end
            end
            tp[k]  = (e >= 3) && (sw_req || (pressed && !p1[k]));
            tsp[k] = (e >= 3) && sw_req;
            p2[k]  = p1[k];
            p1[k]  = pressed;
        end
        q.push_back(expected());
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) model_reset();
        else model_step();
    end

    // Monitor: every falling edge compares the DUT outputs with the oldest expectation.
    always @(negedge clk) begin
        exp_t x;
        logic [7:0] act_rst [3];
        logic       act_rdy [3];
        if (q.size() > 0) begin
            x = q.pop_front();
            act_rst[0] = {6'b0, rst0}; act_rst[1] = {4'b0, rst1}; act_rst[2] = {7'b0, rst2};
            act_rdy[0] = ready0; act_rdy[1] = ready1; act_rdy[2] = ready2;
            for (int k = 0; k < 3; k++) begin
                check($sformatf("sb_rst%0d", k), act_rst[k], x.rst[k]);
                check($sformatf("sb_ready%0d", k), 8'(act_rdy[k]), 8'(x.rdy[k]));
            end
`ifdef RESET_CAUSE_EN
            check("sb_cause0", 8'(cause0), 8'(x.cz[0]));
            check("sb_cause1", 8'(cause1), 8'(x.cz[1]));
            check("sb_cause2", 8'(cause2), 8'(x.cz[2]));
`endif
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Full default-parameter release timing, counted from the first edge after reset_n rises.
    task automatic power_on_checks();
        repeat (64) @(posedge clk);
        #4;
        check("pon_rst_e64", 8'(rst0), 8'h03);
        check("pon_rdy_e64", 8'(ready0), 8'h00);
        @(posedge clk); #4;
        check("pon_rst_e65", 8'(rst0), 8'h02);
        repeat (3) @(posedge clk);
        #4;
        check("pon_rst_e68", 8'(rst0), 8'h02);
        check("pon_rdy_e68", 8'(ready0), 8'h00);
        @(posedge clk); #4;
        check("pon_rst_e69", 8'(rst0), 8'h00);
        check("pon_rdy_e69", 8'(ready0), 8'h01);
        check("pon_rst1_run", 8'(rst1), 8'h00);
`ifdef RESET_CAUSE_EN
        check("pon_cause0", 8'(cause0), 8'h00);
`endif
    endtask

    task automatic async_pulse();
        @(posedge clk);
        #1 reset_n = 1'b0;
        #2;
        check("arst_rst0", 8'(rst0), 8'h03);
        check("arst_rdy0", 8'(ready0), 8'h00);
        check("arst_rst1", 8'(rst1), 8'h0f);
        check("arst_rdy1", 8'(ready1), 8'h00);
        check("arst_rst2", 8'(rst2), 8'h01);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        btn_n   = 1'b1;
        sw_req  = 1'b0;
        #22 reset_n = 1'b1;
        power_on_checks();

        async_pulse();
        repeat (39) @(posedge clk);
        async_pulse();
        power_on_checks();

        // Short glitch: no trigger.
        tick(1);
        btn_n = 1'b0; tick(15); btn_n = 1'b1; tick(30);
        check("glitch_ready0", 8'(ready0), 8'h01);

        // Real press: 2 sync + 16 debounce samples.
        btn_n = 1'b0; tick(18); btn_n = 1'b1;
        @(posedge clk); #4;
        check("press_rst0", 8'(rst0), 8'h03);
        check("press_rdy0", 8'(ready0), 8'h00);
`ifdef RESET_CAUSE_EN
        check("press_cause0", 8'(cause0), 8'h01);
`endif
        tick(100);

        // Held button keeps everything in reset.
        btn_n = 1'b0; tick(200);
        check("held_rst0", 8'(rst0), 8'h03);
        check("held_rst1", 8'(rst1), 8'h0f);
        btn_n = 1'b1; tick(100);

        // Software request, then a second one while staging.
        sw_req = 1'b1; tick(1); sw_req = 1'b0;
        @(posedge clk); #4;
        check("sw_rst0", 8'(rst0), 8'h03);
`ifdef RESET_CAUSE_EN
        check("sw_cause0", 8'(cause0), 8'h02);
`endif
        tick(64);
        check("stage_rst0", 8'(rst0), 8'h02);
        sw_req = 1'b1; tick(1); sw_req = 1'b0;
        @(posedge clk); #4;
        check("restage_rst0", 8'(rst0), 8'h03);
        repeat (2) @(posedge clk);
        #4;
        check("restage_rst0_late", 8'(rst0), 8'h03);
        tick(100);

        // Simultaneous press and software request.
        btn_n = 1'b0; tick(17);
        sw_req = 1'b1; tick(1); sw_req = 1'b0; btn_n = 1'b1;
        @(posedge clk); #4;
        check("both_rst0", 8'(rst0), 8'h03);
`ifdef RESET_CAUSE_EN
        check("both_cause0", 8'(cause0), 8'h02);
`endif
        tick(90);

        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 3))
                0: tick($urandom_range(1, 90));
                1: begin sw_req = 1'b1; tick(1); sw_req = 1'b0; tick($urandom_range(1, 20)); end
                2: begin btn_n = 1'b0; tick($urandom_range(1, 25)); btn_n = 1'b1; tick($urandom_range(1, 20)); end
                default: begin
                    for (int b = 0; b < 4; b++) begin
                        btn_n = 1'b0; tick($urandom_range(1, 6));
                        btn_n = 1'b1; tick($urandom_range(1, 3));
                    end
                end
            endcase
        end
        tick(120);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Board-level reset generator for the FPGA top wrapper. It replaces the fixed power-on counter with a parametrised sequencer.
- Synchronises the external async reset, holds all domains in reset for a programmable time, then releases NUM_DOMAINS reset outputs in staged order.
- Re-runs the sequence on a debounced push-button press or a software request from the core.

Parameters:
- NUM_DOMAINS, 2, number of staged reset outputs (1..8)
- HOLD_CYCLES, 63, cycles all resets stay asserted after internal reset release (>=1)
- STAGE_GAP, 4, cycles between successive domain releases (>=1)
- DEBOUNCE_CYCLES, 16, consecutive synchronised-low samples required to accept a button press (>=2)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- btn_n  in  1  raw push-button, active-low, asynchronous to clk
- sw_req  in  1  single-cycle software reset request, synchronous to clk
- rst  out  NUM_DOMAINS  active-high domain resets; rst[0] is released first
- ready  out  1  high once every domain is released
- cause  out  2  last reset cause; present only with RESET_CAUSE_EN

Behaviour:
- Reset input:
  - reset_n low asynchronously forces rst = all ones, ready = 0, state HOLD, all counters 0, both synchronisers cleared.
  - Deassertion passes through a 2-flop synchroniser (arst_sync). The sequencer is frozen until arst_sync is high.
- Cycle numbering: cycle 1 is the first rising edge with reset_n high. arst_sync goes high at edge 2.
- State HOLD:
  - hold counter increments each cycle while arst_sync = 1 and the debounced button is not pressed.
  - A pressed button freezes the counter at 0.
  - When the counter reaches HOLD_CYCLES: go to STAGE, and rst[0] falls at that edge.
  - With defaults, rst[0] falls at edge 65.
- State STAGE:
  - Stage counter counts STAGE_GAP cycles, then releases the next rst bit.
  - rst[i] falls STAGE_GAP*i edges after rst[0].
  - When the last bit falls, go to RUN and ready rises on the same edge. With defaults: rst[1] and ready change at edge 69.
  - NUM_DOMAINS = 1: go to RUN directly from HOLD; ready rises with rst[0].
  - Released bits stay low. rst is thermometer-coded at all times: bit i never low while bit i-1 is high.
- State RUN: rst = 0 and ready = 1, steady.
- Triggers (debounced press or sw_req = 1):
  - Sampled at edge N, in any state after arst_sync.
  - At edge N+1: rst = all ones, ready = 0, state HOLD, hold and stage counters cleared.
  - A trigger during HOLD or STAGE restarts HOLD from 0.
  - sw_req and a press in the same cycle count as one trigger.
- Debounce:
  - btn_n goes through a 2-flop synchroniser.
  - Debounce counter (width clog2(DEBOUNCE_CYCLES+1)) increments while the synchronised input is low and saturates at DEBOUNCE_CYCLES. Any high sample clears it.
  - "pressed" is counter == DEBOUNCE_CYCLES.
  - A press fires one trigger on its rising edge. A held button does not re-trigger; it only freezes HOLD.
  - Release bounce shorter than DEBOUNCE_CYCLES causes no new trigger.
- Output timing: all outputs are registered; no combinational path from input to output.

Optional Feature:
- Macro RESET_CAUSE_EN.
- Defined:
  - Adds the cause output: 2'b00 power-on, 2'b01 button, 2'b10 software.
  - reset_n low sets 2'b00. Each trigger updates cause at edge N+1; software wins on a simultaneous button/software trigger.
  - Value holds until the next trigger.
- Undefined: the cause port and its register are absent; all other behaviour is identical.

Test Plan:
- Power-on, defaults: release reset_n before edge 1 → rst = 2'b11 through edge 64, 2'b10 at edge 65, 2'b00 with ready = 1 at edge 69.
- Mid-sequence async reset: pull reset_n low at edge 40 for 3 ns → rst = 2'b11 and ready = 0 immediately, no clock needed. After release, the full 65/69 timing repeats from the new cycle 1.
- Button glitch: after ready, btn_n low for 15 cycles then high → no trigger, ready stays 1. Low for 18 cycles (2 sync + 16) → rst = 2'b11 and ready = 0 the edge after pressed.
- Held button: keep btn_n low 200 cycles after a trigger → rst stays 2'b11. After release, rst[0] falls HOLD_CYCLES+1 edges after pressed drops.
- sw_req pulse in RUN at edge N → rst = all ones at N+1, rst[0] released at N+1+HOLD_CYCLES. A second sw_req during STAGE restarts HOLD, and rst[1] is never released early.
- NUM_DOMAINS = 4, STAGE_GAP = 1, RESET_CAUSE_EN defined → rst steps 1111→1110→1100→1000→0000 on consecutive edges. cause = 00 after power-on, 10 after sw_req, 01 after a button press.
